// File: rtl/gal_downcounter.sv
// rtl/gal_downcounter.sv - loadable down-counter with borrow pulse and one-shot/periodic reload
//
// Purpose:
//   Counts down from a loaded value and emits a one-cycle borrow pulse on the
//   terminal edge, where Q steps from 1 to the next value. In periodic mode the
//   count is refilled from a reload register on that edge. In one-shot mode the
//   count parks at zero.
//
// Ports:
//   i_clock    rising-edge clock for all state
//   i_reset    synchronous active-high reset, overrides every other input
//   i_load     copy i_d into the count and the reload register
//   i_clear    zero the count and stop; the reload register is kept
//   i_hold     freeze count and state for this edge
//   i_periodic 1 = auto-reload on terminal count, 0 = one-shot
//   i_d        load value
//   o_q        registered count
//   o_borrow   registered one-cycle terminal-count pulse
//   o_busy     registered, high while counting (RUN)

module gal_downcounter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_hold,
  input  logic             i_periodic,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_borrow,
  output logic             o_busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_borrow;
  logic             r_busy;

  logic             w_q_is_one;
  logic             w_q_is_zero;
  logic             w_d_nonzero;
  logic [WIDTH-1:0] w_q_dec;

  assign w_q_is_one  = (r_q == WIDTH'(1));
  assign w_q_is_zero = (r_q == '0);
  assign w_d_nonzero = (i_d != '0);
  assign w_q_dec     = r_q - WIDTH'(1);

  // Busy is kept as its own flop, updated alongside the state, so the output
  // is a direct register rather than a decode of the state encoding.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
    end else if (i_load) begin
      r_q      <= i_d;
      r_reload <= i_d;
      r_borrow <= 1'b0;
      // Loading zero leaves nothing to count, so the counter stays idle.
      r_state  <= w_d_nonzero ? ST_RUN : ST_IDLE;
      r_busy   <= w_d_nonzero;
    end else if (i_clear) begin
      r_q      <= '0;
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_borrow <= 1'b0;
    end else if (i_hold) begin
      // A held terminal edge is deferred, not lost: Q stays at 1 and the
      // borrow fires on the next un-held edge.
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_borrow <= 1'b0;
        end
        ST_RUN: begin
          if (w_q_is_zero) begin
            // Unreachable in normal operation; recover to a clean idle.
            r_q      <= '0;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_borrow <= 1'b0;
          end else if (w_q_is_one) begin
            r_borrow <= 1'b1;
            if (i_periodic) begin
              r_q <= r_reload;
            end else begin
              r_q     <= '0;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_q      <= w_q_dec;
            r_borrow <= 1'b0;
          end
        end
        default: begin
          r_q      <= '0;
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_borrow <= 1'b0;
        end
      endcase
    end
  end

  assign o_q      = r_q;
  assign o_borrow = r_borrow;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_gal_downcounter.sv
// tb/tb_gal_downcounter.sv - table, directed and random checks for gal_downcounter

module tb_gal_downcounter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld  = 1'b0;
  logic         clr = 1'b0;
  logic         hld = 1'b0;
  logic         per = 1'b0;
  logic [W-1:0] d   = '0;
  logic [W-1:0] q;
  logic         borrow;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state, kept as plain integers.
  int m_q   = 0;
  int m_r   = 0;
  bit m_run = 0;
  bit m_b   = 0;

  typedef struct {
    bit rst, ld, clr, hld, per;
    int d;
    int eq;
    bit eb;
    bit ebusy;
  } vec_t;

  vec_t tbl[$];

  gal_downcounter #(.WIDTH(W)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_load    (ld),
    .i_clear   (clr),
    .i_hold    (hld),
    .i_periodic(per),
    .i_d       (d),
    .o_q       (q),
    .o_borrow  (borrow),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r_i, input bit l_i, input bit c_i,
                            input bit h_i, input bit p_i, input int d_i);
    if (r_i) begin
      m_q = 0; m_r = 0; m_run = 0; m_b = 0;
    end else if (l_i) begin
      m_q = d_i; m_r = d_i; m_run = (d_i != 0); m_b = 0;
    end else if (c_i) begin
      m_q = 0; m_run = 0; m_b = 0;
    end else if (h_i || !m_run) begin
      m_b = 0;
    end else if (m_q > 1) begin
      m_q = m_q - 1; m_b = 0;
    end else if (m_q == 1) begin
      m_b = 1;
      if (p_i) m_q = m_r;
      else begin m_q = 0; m_run = 0; end
    end else begin
      m_q = 0; m_run = 0; m_b = 0;
    end
  endtask

  task automatic step(input bit r_i, input bit l_i, input bit c_i,
                      input bit h_i, input bit p_i, input int d_i);
    rst = r_i; ld = l_i; clr = c_i; hld = h_i; per = p_i; d = W'(d_i);
    @(posedge clk);
    #1;
    model_step(r_i, l_i, c_i, h_i, p_i, d_i);
  endtask

  task automatic add(input bit r_i, input bit l_i, input bit c_i, input bit h_i,
                     input bit p_i, input int d_i, input int eq, input bit eb, input bit ebusy);
    vec_t v;
    v.rst = r_i; v.ld = l_i; v.clr = c_i; v.hld = h_i; v.per = p_i; v.d = d_i;
    v.eq = eq; v.eb = eb; v.ebusy = ebusy;
    tbl.push_back(v);
  endtask

  task automatic chk_out(input string tag, input int eq, input bit eb, input bit ebusy);
    chk({tag, ".q"},      32'(q),      32'(eq));
    chk({tag, ".borrow"}, 32'(borrow), 32'(eb));
    chk({tag, ".busy"},   32'(busy),   32'(ebusy));
  endtask

  initial begin
    int cnt;
    bit seen;

    // Reset dominates a simultaneous load of 0xF.
    add(1,1,0,0,0,15, 0,0,0);
    add(1,1,0,0,0,15, 0,0,0);
    // One-shot D=3.
    add(0,1,0,0,0,3, 3,0,1);
    add(0,0,0,0,0,0, 2,0,1);
    add(0,0,0,0,0,0, 1,0,1);
    add(0,0,0,0,0,0, 0,1,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 0,0,0);
    // Periodic D=4.
    add(0,1,0,0,1,4, 4,0,1);
    for (int k = 0; k < 2; k++) begin
      add(0,0,0,0,1,0, 3,0,1);
      add(0,0,0,0,1,0, 2,0,1);
      add(0,0,0,0,1,0, 1,0,1);
      add(0,0,0,0,1,0, 4,1,1);
    end
    // One-shot D=5 with two hold cycles at Q=2: borrow lands on edge 7, not 5.
    add(0,1,0,0,0,5, 5,0,1);
    add(0,0,0,0,0,0, 4,0,1);
    add(0,0,0,0,0,0, 3,0,1);
    add(0,0,0,0,0,0, 2,0,1);
    add(0,0,0,1,0,0, 2,0,1);
    add(0,0,0,1,0,0, 2,0,1);
    add(0,0,0,0,0,0, 1,0,1);
    add(0,0,0,0,0,0, 0,1,0);
    // Load D=0: stays idle, no borrow.
    add(0,1,0,0,0,0, 0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, 0,0,0);
    // Load wins on a terminal edge.
    add(0,1,0,0,0,2, 2,0,1);
    add(0,0,0,0,0,0, 1,0,1);
    add(0,1,0,0,0,7, 7,0,1);
    for (int v = 6; v >= 1; v--) add(0,0,0,0,0,0, v,0,1);
    // Clear wins on a terminal edge.
    add(0,0,1,0,0,0, 0,0,0);
    add(0,0,0,0,0,0, 0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].clr, tbl[i].hld, tbl[i].per, tbl[i].d);
      chk_out($sformatf("tbl%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].ebusy);
    end

    // Reset wins on a periodic terminal edge, clears R, and nothing restarts.
    step(0,1,0,0,1,2);
    step(0,0,0,0,1,0);
    chk_out("pre_rst", 1, 0, 1);
    step(1,0,0,0,1,0);
    chk_out("rst_term", 0, 0, 0);
    chk("rst_term.r", 32'(dut.r_reload), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0,1,0);
      chk_out("rst_norestart", 0, 0, 0);
    end

    // Full-scale one-shot: borrow after exactly 15 edges.
    step(0,1,0,0,0,15);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0,0,0,0,0,0);
      cnt++;
      if (borrow) seen = 1;
    end
    chk("d15.seen", 32'(seen), 32'd1);
    chk("d15.edges", 32'(cnt), 32'd15);
    chk_out("d15.end", 0, 1, 0);

    // Periodic D=1: borrow every cycle, Q pinned at 1.
    step(0,1,0,0,1,1);
    for (int i = 0; i < 6; i++) begin
      step(0,0,0,0,1,0);
      chk_out("p1", 1, 1, 1);
    end

    // Hold on a periodic terminal edge defers the borrow.
    step(0,1,0,0,1,3);
    step(0,0,0,0,1,0);
    step(0,0,0,0,1,0);
    chk_out("hterm.pre", 1, 0, 1);
    step(0,0,0,1,1,0);
    chk_out("hterm.held", 1, 0, 1);
    step(0,0,0,0,1,0);
    chk_out("hterm.fire", 3, 1, 1);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit rr, rl, rc, rh, rp;
      r  = int'($urandom_range(0, 999));
      rr = (r < 10);
      rl = (r >= 10 && r < 90);
      rc = (r >= 90 && r < 130);
      rh = ($urandom_range(0, 4) == 0);
      rp = (i % 400) < 250;
      step(rr, rl, rc, rh, rp, int'($urandom_range(0, 15)));
      chk_out("rnd", m_q, m_b, m_run);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
